// File: rtl/rv2t_uart_pkg.sv
// Shared UART receive definitions: data width, default baud period and receiver FSM states.
// The parity state is only reachable when UART_RX_PARITY_EN is defined.
package rv2t_uart_pkg;

    localparam int unsigned UART_TX_BAUD_PERIOD  = 16;
    localparam int unsigned UART_RX_DATA_WIDTH   = 8;
    localparam int unsigned UART_RX_DEFAULT_BAUD = UART_TX_BAUD_PERIOD;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } rx_state_e;

    // Even parity holds when the data bits and the parity bit XOR to zero.
    function automatic logic even_parity_ok(input logic [UART_RX_DATA_WIDTH-1:0] data,
                                            input logic parity);
        return ~(^{data, parity});
    endfunction

endpackage

// File: rtl/rv2t_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; flags a dropped push while full.
module rv2t_rx_fifo #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ADDR_BITS = 3
) (
    input  logic             clk,
    input  logic             sync_reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full,
    output logic             overflow
);

    localparam int unsigned DEPTH = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS:0] CountOne = (ADDR_BITS + 1)'(1);
    localparam logic [ADDR_BITS-1:0] PtrOne = ADDR_BITS'(1);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [ADDR_BITS-1:0] wptr;
    logic [ADDR_BITS-1:0] rptr;
    logic [ADDR_BITS:0]   count;
    logic                 do_push;
    logic                 do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (ADDR_BITS + 1)'(DEPTH));
    assign do_pop   = pop && !empty;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
    assign do_push  = push && (!full || do_pop);
    assign overflow = push && full && !pop;
    assign head     = empty ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + PtrOne;
            end
            if (do_pop) begin
                rptr <= rptr + PtrOne;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CountOne;
                2'b01:   count <= count - CountOne;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rv2t_uart_rx.sv
// CPU-side 8N1 UART receiver with FWFT byte FIFO and sticky error flags.
// Define UART_RX_PARITY_EN for even-parity framing and the parity_error output.
module rv2t_uart_rx
    import rv2t_uart_pkg::*;
#(
    parameter int unsigned BAUD_PERIOD    = UART_RX_DEFAULT_BAUD,
    parameter int unsigned FIFO_ADDR_BITS = 3
) (
    input  logic                          clk,
    input  logic                          sync_reset,
    input  logic                          RXD,
    input  logic                          enable_in,
    input  logic                          rd_en,
    output logic [UART_RX_DATA_WIDTH-1:0] data_out,
    output logic                          data_valid,
    output logic                          fifo_full,
    output logic                          overrun,
    output logic                          frame_error,
`ifdef UART_RX_PARITY_EN
    output logic                          parity_error,
`endif
    input  logic                          clr_errors
);

    localparam int unsigned DW = UART_RX_DATA_WIDTH;
    localparam int unsigned CW = $clog2(BAUD_PERIOD);
    localparam logic [CW-1:0] CntHalf = CW'(BAUD_PERIOD / 2 - 1);
    localparam logic [CW-1:0] CntFull = CW'(BAUD_PERIOD - 1);
    localparam logic [CW-1:0] CntOne  = CW'(1);
    localparam logic [2:0]    LastBit = 3'(DW - 1);

    logic [1:0]    sync_q;
    logic          rxd_s;
    rx_state_e     state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [DW-1:0] shreg;
    logic          tick;
    logic          push;
    logic          fifo_empty;
    logic          fifo_ovf;
    logic          frame_error_q;
    logic          overrun_q;
`ifdef UART_RX_PARITY_EN
    logic          parity_error_q;
    logic          par_bad_q;
`endif

    assign rxd_s = sync_q[1];
    assign tick  = (baud_cnt == '0);
`ifdef UART_RX_PARITY_EN
    assign push  = (state == StStop) && tick && rxd_s && !par_bad_q;
    assign parity_error = parity_error_q;
`else
    assign push  = (state == StStop) && tick && rxd_s;
`endif
    assign data_valid  = !fifo_empty;
    assign frame_error = frame_error_q;
    assign overrun     = overrun_q;

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], RXD};
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state         <= StIdle;
            baud_cnt      <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            frame_error_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error_q <= 1'b0;
            par_bad_q      <= 1'b0;
`endif
        end else begin
            // Clear first so a same-cycle set below takes priority.
            frame_error_q <= frame_error_q & ~clr_errors;
`ifdef UART_RX_PARITY_EN
            parity_error_q <= parity_error_q & ~clr_errors;
`endif
            if (state != StIdle && state != StBreak && !tick) begin
                baud_cnt <= baud_cnt - CntOne;
            end
            unique case (state)
                StIdle: begin
                    if (!rxd_s && enable_in) begin
                        baud_cnt <= CntHalf;
                        state    <= StStart;
                    end
                end
                StStart: begin
                    if (tick) begin
                        if (rxd_s) begin
                            state <= StIdle;
                        end else begin
                            baud_cnt <= CntFull;
                            bit_idx  <= '0;
`ifdef UART_RX_PARITY_EN
                            par_bad_q <= 1'b0;
`endif
                            state    <= StData;
                        end
                    end
                end
                StData: begin
                    if (tick) begin
                        shreg    <= {rxd_s, shreg[DW-1:1]};
                        bit_idx  <= bit_idx + 3'd1;
                        baud_cnt <= CntFull;
                        if (bit_idx == LastBit) begin
`ifdef UART_RX_PARITY_EN
                            state <= StParity;
`else
                            state <= StStop;
`endif
                        end
                    end
                end
                StParity: begin
                    if (tick) begin
`ifdef UART_RX_PARITY_EN
                        par_bad_q <= !even_parity_ok(shreg, rxd_s);
                        if (!even_parity_ok(shreg, rxd_s)) begin
                            parity_error_q <= 1'b1;
                        end
`endif
                        baud_cnt <= CntFull;
                        state    <= StStop;
                    end
                end
                StStop: begin
                    if (tick) begin
                        if (rxd_s) begin
                            state <= StIdle;
                        end else begin
                            frame_error_q <= 1'b1;
                            state         <= StBreak;
                        end
                    end
                end
                StBreak: begin
                    if (rxd_s) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= fifo_ovf | (overrun_q & ~clr_errors);
        end
    end

    rv2t_rx_fifo #(
        .WIDTH    (DW),
        .ADDR_BITS(FIFO_ADDR_BITS)
    ) u_fifo (
        .clk       (clk),
        .sync_reset(sync_reset),
        .push      (push),
        .push_data (shreg),
        .pop       (rd_en),
        .head      (data_out),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .overflow  (fifo_ovf)
    );

endmodule

// File: tb/tb_rv2t_uart_rx.sv
// Scoreboard bench for rv2t_uart_rx: expected bytes queued at send time, checked on each pop.
module tb_rv2t_uart_rx;

    localparam int BP = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 10;
`else
    localparam int NB = 9;
`endif

    logic       clk;
    logic       sync_reset;
    logic       RXD;
    logic       enable_in;
    logic       rd_en;
    logic [7:0] data_out;
    logic       data_valid;
    logic       fifo_full;
    logic       overrun;
    logic       frame_error;
    logic       clr_errors;
`ifdef UART_RX_PARITY_EN
    logic       parity_error;
`endif

    int         checks;
    int         errors;
    logic [7:0] exp_q[$];
    logic       reader_on;

    rv2t_uart_rx #(
        .BAUD_PERIOD   (BP),
        .FIFO_ADDR_BITS(3)
    ) dut (
        .clk        (clk),
        .sync_reset (sync_reset),
        .RXD        (RXD),
        .enable_in  (enable_in),
        .rd_en      (rd_en),
        .data_out   (data_out),
        .data_valid (data_valid),
        .fifo_full  (fifo_full),
        .overrun    (overrun),
        .frame_error(frame_error),
`ifdef UART_RX_PARITY_EN
        .parity_error(parity_error),
`endif
        .clr_errors (clr_errors)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Line is left at the stop-bit level afterwards.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic chk_pre);
        RXD = 1'b0;
        tick(BP);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            tick(BP);
        end
`ifdef UART_RX_PARITY_EN
        RXD = ^b;
        tick(BP);
`endif
        RXD = stop_bit;
        if (chk_pre) begin
            tick(4);
            check("valid_before_stop_sample", data_valid, 1'b0);
            tick(BP - 4);
        end else begin
            tick(BP);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        reader_on = 1'b1;
        while ((exp_q.size() != 0 || data_valid) && n < 3000) begin
            tick(1);
            n++;
        end
        reader_on = 1'b0;
        rd_en = 1'b0;
        tick(1);
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_valid_low", data_valid, 1'b0);
    endtask

    // Random reader: pops now and then while enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reader_on) rd_en = data_valid && ($urandom_range(0, 2) == 0);
        end
    end

    // Monitor: a pop happens on the next edge whenever rd_en and data_valid are both high.
    always @(negedge clk) begin
        if (!sync_reset && rd_en && data_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got %0h, expected no data", data_out);
            end else begin
                check("pop_data", data_out, exp_q.pop_front());
            end
        end
    end

    initial begin
        #(10 * 90000);
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        checks     = 0;
        errors     = 0;
        reader_on  = 1'b0;
        sync_reset = 1'b1;
        RXD        = 1'b1;
        enable_in  = 1'b1;
        rd_en      = 1'b0;
        clr_errors = 1'b0;
        tick(3);
        sync_reset = 1'b0;
        tick(2);
        check("reset_data_out", data_out, 8'h00);
        check("reset_data_valid", data_valid, 1'b0);
        check("reset_fifo_full", fifo_full, 1'b0);
        check("reset_overrun", overrun, 1'b0);
        check("reset_frame_error", frame_error, 1'b0);

        // Basic receive and single pop.
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b1);
        check("basic_valid", data_valid, 1'b1);
        check("basic_head", data_out, 8'hA5);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        check("basic_valid_after_pop", data_valid, 1'b0);
        check("basic_data_after_pop", data_out, 8'h00);

        // False start glitch.
        RXD = 1'b0;
        tick(5);
        RXD = 1'b1;
        tick(10 * BP);
        check("glitch_valid", data_valid, 1'b0);
        check("glitch_frame_error", frame_error, 1'b0);
        check("glitch_overrun", overrun, 1'b0);

        // Disabled receiver ignores a frame.
        enable_in = 1'b0;
        send_frame(8'h5A, 1'b1, 1'b0);
        enable_in = 1'b1;
        tick(3 * BP);
        check("disabled_valid", data_valid, 1'b0);

        // Framing error followed by a line break.
        send_frame(8'h3C, 1'b0, 1'b0);
        tick(40);
        check("ferr_set", frame_error, 1'b1);
        check("ferr_fifo_empty", data_valid, 1'b0);
        RXD = 1'b1;
        tick((NB + 3) * BP);
        check("break_no_retrigger", data_valid, 1'b0);
        clr_errors = 1'b1;
        tick(1);
        clr_errors = 1'b0;
        check("ferr_cleared", frame_error, 1'b0);

        // Randomised traffic with the random reader draining.
        reader_on = 1'b1;
        for (int i = 0; i < 20; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_frame(b, 1'b1, 1'b0);
            tick($urandom_range(1, 10));
        end
        drain();
        check("random_no_overrun", overrun, 1'b0);
        check("random_no_ferr", frame_error, 1'b0);

        // Overflow: nine bytes into an eight-deep FIFO.
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1, 1'b0);
        end
        check("ovf_full", fifo_full, 1'b1);
        check("ovf_overrun", overrun, 1'b1);
        rd_en = 1'b1;
        tick(8);
        rd_en = 1'b0;
        check("ovf_empty_after_pops", data_valid, 1'b0);
        check("ovf_data_zero", data_out, 8'h00);
        check("ovf_full_clear", fifo_full, 1'b0);
        clr_errors = 1'b1;
        tick(1);
        clr_errors = 1'b0;
        check("ovf_cleared", overrun, 1'b0);

        // Full FIFO with pops straddling the push of 0x55.
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_frame(b, 1'b1, 1'b0);
        end
        check("full_before_55", fifo_full, 1'b1);
        exp_q.push_back(8'h55);
        fork
            send_frame(8'h55, 1'b1, 1'b0);
            begin
                tick(BP * NB + 10);
                rd_en = 1'b1;
                tick(2);
                rd_en = 1'b0;
            end
        join
        check("simul_no_overrun", overrun, 1'b0);
        drain();

        // Reset during data bit 4 of 0xFF, with a stale byte already buffered.
        send_frame(8'h77, 1'b1, 1'b0);
        check("prefill_valid", data_valid, 1'b1);
        fork
            send_frame(8'hFF, 1'b1, 1'b0);
            begin
                tick(BP * 5 + 8);
                sync_reset = 1'b1;
                tick(1);
                sync_reset = 1'b0;
            end
        join
        tick(2 * BP);
        check("rst_data_out", data_out, 8'h00);
        check("rst_data_valid", data_valid, 1'b0);
        check("rst_fifo_full", fifo_full, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_frame_error", frame_error, 1'b0);
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1, 1'b0);
        check("post_rst_valid", data_valid, 1'b1);
        check("post_rst_head", data_out, 8'h12);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
